// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared fetch-stage types, state encodings and PC constants
package stage_if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-deep instruction buffer with push, pop, flush and count
module fetch_fifo
  import stage_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  if_entry_t  push_data,
  input  logic       pop,
  input  logic       flush,
  output if_entry_t  head_data,
  output logic [1:0] count
);

  if_entry_t mem [2];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      do_push;
  logic      do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage carries no reset; contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage: request FSM, PC tracking and redirect handling
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  if_state_e   state;
  if_state_e   state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] target_pc;
  logic [31:0] target_next;
  logic        req;
  logic        req_next;
  logic [1:0]  count;
  logic        flush;
  logic        ack;
  logic        pop;
  logic        push;
  logic [31:0] flush_pc;
  logic [2:0]  demand;
  if_entry_t   head;

  assign flush    = if_rst || redirect_valid;
  assign flush_pc = if_rst ? RESET_PC : pc_align(redirect_pc);
  assign ack      = req && imem_ack;
  assign if_valid = (count != 2'd0);
  assign pop      = if_en && if_valid && !flush;
  assign push     = ack && (state == FETCH) && !flush;
  assign demand   = {1'b0, count} + {2'b00, req} - {2'b00, pop};

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ('{pc: pc, inst: imem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (flush && req && !ack) state_next = DROP;
      DROP:    if (ack) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // pc is the address of the current/next request; in DROP it still holds the abandoned
  // address so imem_addr stays stable, while target_pc holds where to resume.
  always_comb begin
    pc_next     = pc;
    req_next    = req;
    target_next = target_pc;
    if (state == FETCH) begin
      if (flush) begin
        if (req && !ack) begin
          target_next = flush_pc;
        end else begin
          pc_next  = flush_pc;
          req_next = 1'b1;
        end
      end else if (!req || ack) begin
        if (ack) pc_next = pc + PC_STEP;
        req_next = (demand < 3'd2);
      end
    end else begin
      if (flush) target_next = flush_pc;
      if (ack) begin
        pc_next  = flush ? flush_pc : target_pc;
        req_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      target_pc <= RESET_PC;
      req       <= 1'b0;
    end else begin
      pc        <= pc_next;
      target_pc <= target_next;
      req       <= req_next;
    end
  end

  always_comb begin
    imem_req  = req;
    imem_addr = pc;
    inst_out  = '0;
    pc_out    = '0;
    if (if_valid) begin
      inst_out = head.inst;
      pc_out   = head.pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - randomized and directed bench for stage_if against a queue-based model
module tb_stage_if;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_rst = 1'b0;
  logic        if_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  stage_if #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_rst         (if_rst),
    .if_en          (if_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .inst_out       (inst_out),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic        m_req;
  logic        m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_target;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req    = 1'b0;
    m_drop   = 1'b0;
    m_addr   = RST_PC;
    m_target = RST_PC;
  endtask

  task automatic compare_all();
    logic v;
    v = (q.size() != 0);
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    check("imem_addr", imem_addr, m_addr);
    check("if_valid", {31'b0, if_valid}, {31'b0, v});
    check("inst_out", inst_out, v ? q[0].inst : 32'h0);
    check("pc_out", pc_out, v ? q[0].pc + 32'd4 : 32'h0);
  endtask

  // Buffer is a queue; a new request is issued whenever no request is outstanding
  // and the buffer will have a free slot after this edge.
  task automatic model_step(input logic en, input logic ack, input logic rv,
                            input logic [31:0] rpc, input logic rs);
    logic        flush;
    logic        acc;
    logic [31:0] fpc;
    ent_t        e;
    flush = rs | rv;
    fpc   = rs ? RST_PC : {rpc[31:2], 2'b00};
    acc   = m_req & ack;
    if (m_drop) begin
      if (flush) m_target = fpc;
      if (acc) begin
        m_drop = 1'b0;
        m_addr = m_target;
        m_req  = 1'b1;
      end
    end else if (flush) begin
      q.delete();
      if (m_req && !acc) begin
        m_drop   = 1'b1;
        m_target = fpc;
      end else begin
        m_addr = fpc;
        m_req  = 1'b1;
      end
    end else begin
      if (en && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        e.pc   = m_addr;
        e.inst = mem_word(m_addr);
        q.push_back(e);
        m_addr = m_addr + 32'd4;
      end
      if (!m_req || acc) m_req = (q.size() < 2);
    end
  endtask

  // Called at a falling edge: drive, step through one rising edge, compare at the next fall.
  task automatic cycle(input logic en, input logic ack, input logic rv,
                       input logic [31:0] rpc, input logic rs);
    if_en          = en;
    imem_ack       = ack;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_rst         = rs;
    imem_rdata     = ack ? mem_word(m_addr) : $urandom;
    @(posedge clk);
    model_step(en, ack, rv, rpc, rs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input logic [31:0] addr);
    int n;
    n = 0;
    while (!(m_req && m_addr == addr) && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      n++;
    end
    check("reach_addr", m_addr, addr);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // streaming start-up, one instruction per cycle
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (k >= 2) begin
        check("start_addr", imem_addr, 32'(4 * (k - 1)));
        check("start_pc_out", pc_out, 32'(4 * (k - 1)));
      end
    end

    // redirect while a request is outstanding goes through DROP
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run_to(32'h8);
    cycle(1'b1, 1'b0, 1'b1, 32'h103, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("drop_valid", {31'b0, if_valid}, 32'h0);
    check("drop_target", imem_addr, 32'h100);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // redirect coinciding with ack skips DROP
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    run_to(32'hC);
    cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
    check("same_cyc_addr", imem_addr, 32'h200);
    check("same_cyc_valid", {31'b0, if_valid}, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("same_cyc_pc", pc_out, 32'h204);

    // stall with ack always ready: buffer fills to 2 and requests stop
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_req", {31'b0, imem_req}, 32'h0);
    check("stall_head_pc", pc_out, 32'h4);
    check("stall_head_inst", inst_out, mem_word(32'h0));
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("resume_pc", pc_out, 32'h8);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // if_rst wins over a simultaneous redirect on a full buffer
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("full_valid", {31'b0, if_valid}, 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
    check("rst_win_valid", {31'b0, if_valid}, 32'h0);
    check("rst_win_addr", imem_addr, RST_PC);

    // asynchronous reset during a request to 0x10, late ack afterwards
    run_to(32'h10);
    if_en = 1'b0;
    imem_ack = 1'b1;
    redirect_valid = 1'b0;
    if_rst = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("arst_restart", imem_addr, 32'h0);
    check("arst_req", {31'b0, imem_req}, 32'h1);
    check("arst_valid", {31'b0, if_valid}, 32'h0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rpc;
      rpc = ($urandom % 8 == 0) ? 32'hFFFF_FFF9 : $urandom;
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0,
            rpc, ($urandom % 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 if_rst  in  1  synchronous stage re-init from the pipeline controller.
REQ-005 if_en  in  1  stage enable; ID accepts the head instruction at an edge where if_en=1 and if_valid=1.
REQ-006 redirect_valid  in  1  one-cycle pulse; a resolved jump/branch changes the PC.
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_ack  in  1  one-cycle response strobe; sampled only while imem_req=1.
REQ-011 imem_rdata  in  32  instruction data, valid with imem_ack.
REQ-012 if_valid  out  1  the head instruction is present.
REQ-013 inst_out  out  32  the head instruction, driven to ID and the controller decoder.
REQ-014 pc_out  out  32  head instruction address + 4, used for the link value.

Function
REQ-015 The block SHALL hold a 2-entry instruction buffer (instruction plus PC per entry), and if_valid SHALL equal buffer-not-empty.
REQ-016 A pop SHALL occur at an edge where if_en=1 and if_valid=1.
REQ-017 A push SHALL occur at an edge where imem_ack=1 in FETCH with no redirect or if_rst in that cycle.
REQ-018 Push and pop SHALL be allowed in the same edge; the buffer count SHALL never exceed 2.
REQ-019 The FSM SHALL have two states: FETCH and DROP. At most one request SHALL be outstanding.
REQ-020 In FETCH, a new request SHALL start only when (count + outstanding − pop this cycle) < 2.
REQ-021 Once raised, imem_req SHALL stay high, and imem_addr SHALL stay stable, until imem_ack, independent of if_en.
REQ-022 On an accepted ack in FETCH, pc SHALL become pc+4 (modulo 2^32), and the next request MAY be issued in the following cycle.
REQ-023 With ack in the same cycle as req and if_en=1, throughput SHALL be 1 instruction/cycle.
REQ-024 Latency from ack to if_valid SHALL be 1 cycle.
REQ-025 On redirect_valid, the buffer SHALL be flushed and pc SHALL become {redirect_pc[31:2],2'b00}.
REQ-026 If a request is outstanding and its ack is not in the same cycle, the FSM SHALL go to DROP.
REQ-027 In DROP, the FSM SHALL keep req and addr of the old request until ack, discard the returned data, then return to FETCH and fetch the redirect address.
REQ-028 A further redirect while in DROP SHALL replace the pending target.
REQ-029 Redirect in the same cycle as ack SHALL discard that data, skip DROP, and set the next imem_addr to the redirect target.
REQ-030 if_rst=1 SHALL behave as a redirect to RESET_PC.
REQ-031 If if_rst and redirect_valid occur together, if_rst SHALL win.
REQ-032 Flush SHALL take priority over a pop in the same cycle.
REQ-033 inst_out and pc_out SHALL be 0 when if_valid=0.

Reset
REQ-034 While rst_n=0, the block SHALL drive imem_req=0, imem_addr=RESET_PC, if_valid=0, inst_out=0, pc_out=0, buffer empty, state FETCH, pc=RESET_PC.
REQ-035 The first request SHALL be raised in the first cycle after rst_n deasserts.
REQ-036 An outstanding request cut by rst_n SHALL be abandoned; an ack that arrives later while imem_req=0 SHALL be ignored.

Structure
REQ-037 The FSM state encodings and RESET_PC default SHALL live in the shared define header alongside the PC_* and EXE_* constants.
REQ-038 The buffer SHALL be a sub-module fetch_fifo (2-deep, 64-bit entries, push/pop/flush, count output); the FSM and PC logic SHALL be in stage_if.

Verification
REQ-039 Release reset, ack every cycle, if_en=1 -> imem_addr 0x0,0x4,0x8…; if_valid from cycle 2; pc_out 0x4,0x8,… one per cycle.
REQ-040 if_en=0 for 5 cycles with ack always ready -> exactly 2 instructions buffered, imem_req low, and on resume instructions 0x0,0x4 appear in order with none lost or duplicated.
REQ-041 Request to 0x8 outstanding, redirect_pc=0x103 pulsed, ack 3 cycles later -> data for 0x8 never reaches if_valid, and the next imem_addr is 0x100.
REQ-042 redirect_pc=0x200 in the same cycle as ack for 0xC -> no DROP; the next imem_addr is 0x200, and the 0xC data is discarded.
REQ-043 Buffer full, if_rst and redirect_valid (0x300) together -> if_valid=0 next cycle, and the next fetch is at RESET_PC.
REQ-044 rst_n asserted mid-request to 0x10, late ack after release -> outputs at reset values, the late ack is ignored, and fetch restarts at 0x0.
